// File: rtl/comspc_video_pkg.sv
// Shared constants for the video mixer: layer bit positions, per-layer palette
// entries for colour and monochrome modes, and the channel saturation limit.
package comspc_video_pkg;

  localparam int STAR_BIT   = 0;
  localparam int SAUCER_BIT = 1;
  localparam int ROCKET_BIT = 2;
  localparam int INV_BIT    = 3;

  localparam logic [3:0] SAT_LIM = 4'd15;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  localparam rgb_t STAR_RGB    = '{r: 4'd7,  g: 4'd7,  b: 4'd7};
  localparam rgb_t SAUCER_COL  = '{r: 4'd0,  g: 4'd15, b: 4'd15};
  localparam rgb_t SAUCER_MONO = '{r: 4'd7,  g: 4'd7,  b: 4'd7};
  localparam rgb_t ROCKET_COL  = '{r: 4'd15, g: 4'd15, b: 4'd0};
  localparam rgb_t ROCKET_MONO = '{r: 4'd15, g: 4'd15, b: 4'd15};

endpackage

// File: rtl/comspc_invert_latch.sv
// Frame-level state: vsync edge detect, invert request accumulator, active
// invert flag and palette select, all updated once per frame boundary.
module comspc_invert_latch
  import comspc_video_pkg::*;
(
  input  logic clk_sys,
  input  logic reset_n,
  input  logic i_ce_pix,
  input  logic i_vsync,
  input  logic i_vs_rise_p1,
  input  logic i_inv_req_p1,
  input  logic i_color_en_p1,
  output logic o_vs_rise,
  output logic o_inv,
  output logic o_pal
);

  logic r_prev_vs;
  logic r_acc;
  logic r_inv;
  logic r_pal;

  assign o_vs_rise = i_vsync & ~r_prev_vs;
  assign o_inv     = r_inv;
  assign o_pal     = r_pal;

  // Works on the stage-1 copy of the edge flag so the frame swap lines up with
  // the pixel pipeline; the edge-cycle request seeds the next frame's accumulator.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_prev_vs <= 1'b0;
      r_acc     <= 1'b0;
      r_inv     <= 1'b0;
      r_pal     <= 1'b0;
    end else if (i_ce_pix) begin
      r_prev_vs <= i_vsync;
      if (i_vs_rise_p1) begin
        r_inv <= r_acc;
        r_acc <= i_inv_req_p1;
        r_pal <= i_color_en_p1;
      end else begin
        r_acc <= r_acc | i_inv_req_p1;
      end
    end
  end

endmodule

// File: rtl/comspc_video_mixer.sv
// Two-stage pixel mixer: layer bits and timing are registered, then the layer
// colours are summed, saturated, optionally inverted and blanked.
module comspc_video_mixer
  import comspc_video_pkg::*;
(
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       ce_pix,
  input  logic [3:0] video,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       hblank_in,
  input  logic       vblank_in,
  input  logic       color_en,
  output logic [3:0] r,
  output logic [3:0] g,
  output logic [3:0] b,
  output logic       hsync,
  output logic       vsync,
  output logic       hblank,
  output logic       vblank
);

  logic [3:0] r_video_p1;
  logic       r_hs_p1, r_vs_p1, r_hb_p1, r_vb_p1;
  logic       r_vs_rise_p1;
  logic       r_color_en_p1;

  logic       w_vs_rise;
  logic       w_inv;
  logic       w_pal;
  rgb_t       w_star, w_sauc, w_rock;
  logic [5:0] w_sum_r, w_sum_g, w_sum_b;

  function automatic rgb_t layer_rgb(input logic en, input rgb_t c);
    return en ? c : '0;
  endfunction

  function automatic logic [3:0] sat4(input logic [5:0] s);
    return (s > {2'b00, SAT_LIM}) ? SAT_LIM : s[3:0];
  endfunction

  comspc_invert_latch u_inv_latch (
    .clk_sys       (clk_sys),
    .reset_n       (reset_n),
    .i_ce_pix      (ce_pix),
    .i_vsync       (vsync_in),
    .i_vs_rise_p1  (r_vs_rise_p1),
    .i_inv_req_p1  (r_video_p1[INV_BIT]),
    .i_color_en_p1 (r_color_en_p1),
    .o_vs_rise     (w_vs_rise),
    .o_inv         (w_inv),
    .o_pal         (w_pal)
  );

  // Stage 1: capture layer bits, timing and the frame-edge flag
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_video_p1    <= '0;
      r_hs_p1       <= 1'b0;
      r_vs_p1       <= 1'b0;
      r_hb_p1       <= 1'b0;
      r_vb_p1       <= 1'b0;
      r_vs_rise_p1  <= 1'b0;
      r_color_en_p1 <= 1'b0;
    end else if (ce_pix) begin
      r_video_p1    <= video;
      r_hs_p1       <= hsync_in;
      r_vs_p1       <= vsync_in;
      r_hb_p1       <= hblank_in;
      r_vb_p1       <= vblank_in;
      r_vs_rise_p1  <= w_vs_rise;
      r_color_en_p1 <= color_en;
    end
  end

  assign w_star  = layer_rgb(r_video_p1[STAR_BIT],   STAR_RGB);
  assign w_sauc  = layer_rgb(r_video_p1[SAUCER_BIT], w_pal ? SAUCER_COL : SAUCER_MONO);
  assign w_rock  = layer_rgb(r_video_p1[ROCKET_BIT], w_pal ? ROCKET_COL : ROCKET_MONO);
  assign w_sum_r = {2'b00, w_star.r} + {2'b00, w_sauc.r} + {2'b00, w_rock.r};
  assign w_sum_g = {2'b00, w_star.g} + {2'b00, w_sauc.g} + {2'b00, w_rock.g};
  assign w_sum_b = {2'b00, w_star.b} + {2'b00, w_sauc.b} + {2'b00, w_rock.b};

  // Stage 2: saturate, invert, blank
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r      <= '0;
      g      <= '0;
      b      <= '0;
      hsync  <= 1'b0;
      vsync  <= 1'b0;
      hblank <= 1'b0;
      vblank <= 1'b0;
    end else if (ce_pix) begin
      hsync  <= r_hs_p1;
      vsync  <= r_vs_p1;
      hblank <= r_hb_p1;
      vblank <= r_vb_p1;
      if (r_hb_p1 | r_vb_p1) begin
        r <= '0;
        g <= '0;
        b <= '0;
      end else begin
        r <= sat4(w_sum_r) ^ {4{w_inv}};
        g <= sat4(w_sum_g) ^ {4{w_inv}};
        b <= sat4(w_sum_b) ^ {4{w_inv}};
      end
    end
  end

endmodule

// File: tb/tb_comspc_video_mixer.sv
// Directed bench for the video mixer: palettes, saturation, frame-latched
// invert, blanking, pixel-enable freeze and asynchronous reset.
module tb_comspc_video_mixer;

  logic       clk_sys = 1'b0;
  logic       reset_n;
  logic       ce_pix;
  logic [3:0] video;
  logic       hsync_in, vsync_in, hblank_in, vblank_in;
  logic       color_en;
  logic [3:0] r, g, b;
  logic       hsync, vsync, hblank, vblank;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk_sys = ~clk_sys;

  comspc_video_mixer dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .ce_pix    (ce_pix),
    .video     (video),
    .hsync_in  (hsync_in),
    .vsync_in  (vsync_in),
    .hblank_in (hblank_in),
    .vblank_in (vblank_in),
    .color_en  (color_en),
    .r         (r),
    .g         (g),
    .b         (b),
    .hsync     (hsync),
    .vsync     (vsync),
    .hblank    (hblank),
    .vblank    (vblank)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      @(negedge clk_sys);
    end
  endtask

  function automatic logic [15:0] rgb();
    return {4'h0, r, g, b};
  endfunction

  // One vblank/vsync interval; edge_req drives video[3] only on the first vsync cycle
  task automatic frame(input logic edge_req);
    vsync_in  = 1'b1;
    vblank_in = 1'b1;
    video     = {edge_req, 3'b000};
    tick(1);
    video = 4'b0000;
    tick(2);
    vsync_in  = 1'b0;
    vblank_in = 1'b0;
    tick(3);
  endtask

  initial begin
    reset_n   = 1'b0;
    ce_pix    = 1'b1;
    video     = 4'b0111;
    hsync_in  = 1'b1;
    vsync_in  = 1'b1;
    hblank_in = 1'b1;
    vblank_in = 1'b1;
    color_en  = 1'b1;
    tick(3);
    check("reset_rgb",    rgb(), 16'h000);
    check("reset_timing", {12'h0, hsync, vsync, hblank, vblank}, 16'h0);
    check("reset_inv",    {15'h0, dut.w_inv}, 16'h0);
    check("reset_pal",    {15'h0, dut.w_pal}, 16'h0);

    video = 4'b0000; hsync_in = 0; vsync_in = 0; hblank_in = 0; vblank_in = 0;
    reset_n = 1'b1;
    frame(1'b0);

    // Colour palette
    video = 4'b0001; tick(2); check("col_star",   rgb(), 16'h777);
    video = 4'b0110; tick(2); check("col_sat",    rgb(), 16'hFFF);
    video = 4'b0010; tick(2); check("col_saucer", rgb(), 16'h0FF);
    video = 4'b0100; tick(2); check("col_rocket", rgb(), 16'hFF0);

    hsync_in = 1'b1; tick(1);
    check("hsync_lat1", {15'h0, hsync}, 16'h0);
    tick(1);
    check("hsync_lat2", {15'h0, hsync}, 16'h1);
    hsync_in = 1'b0;

    // Palette change mid-frame does not take effect yet
    color_en = 1'b0;
    video = 4'b0010; tick(2); check("pal_hold", rgb(), 16'h0FF);
    frame(1'b0);
    video = 4'b0111; tick(2); check("mono_all",  rgb(), 16'hFFF);
    video = 4'b0011; tick(2); check("mono_14",   rgb(), 16'hEEE);
    video = 4'b0000; tick(2); check("mono_zero", rgb(), 16'h000);

    // Mid-frame invert request applies to the following frame only
    video = 4'b1000; tick(1);
    video = 4'b0000; tick(3);
    check("inv_same_frame", rgb(), 16'h000);
    frame(1'b0);
    check("inv_next_frame", rgb(), 16'hFFF);
    check("inv_flag_set",   {15'h0, dut.w_inv}, 16'h1);
    frame(1'b0);
    check("inv_cleared",    rgb(), 16'h000);

    // Request on the vsync edge cycle counts toward the new frame
    frame(1'b1);
    check("edge_req_n1", rgb(), 16'h000);
    frame(1'b0);
    check("edge_req_n2", rgb(), 16'hFFF);

    // Blanking overrides inversion, aligned with delayed hblank
    hblank_in = 1'b1; video = 4'b0100; tick(2);
    check("hblank_rgb", rgb(), 16'h000);
    check("hblank_out", {15'h0, hblank}, 16'h1);
    hblank_in = 1'b0;

    // Pixel-enable freeze
    video = 4'b0001; tick(2); check("pre_freeze", rgb(), 16'h888);
    ce_pix = 1'b0; video = 4'b0000; hsync_in = 1'b1;
    tick(10);
    check("freeze_rgb",   rgb(), 16'h888);
    check("freeze_hsync", {15'h0, hsync}, 16'h0);
    ce_pix = 1'b1; hsync_in = 1'b0;
    tick(2); check("post_freeze", rgb(), 16'hFFF);

    // Asynchronous reset mid-frame
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_rgb", rgb(), 16'h000);
    check("async_rst_inv", {15'h0, dut.w_inv}, 16'h0);
    @(negedge clk_sys);
    reset_n = 1'b1;
    video = 4'b0001; tick(1);
    check("rst_lat1", rgb(), 16'h000);
    tick(1);
    check("rst_first_px", rgb(), 16'h777);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/comspc_video_mixer.md
COMSPC_VIDEO_MIXER -- requirements
Module: comspc_video_mixer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, declared first: clk_sys in 1, game pixel clock; all logic on its rising edge. reset_n in 1, asynchronous active-low reset.
REQ-002 The block SHALL provide port ce_pix in 1: pixel enable; all state advances only when ce_pix=1.
REQ-003 The block SHALL provide port video in 4: layer bits; [0]=star, [1]=saucer, [2]=rocket/score, [3]=invert request.
REQ-004 The block SHALL provide ports hsync_in, vsync_in, hblank_in, vblank_in, each in 1: raw timing from the game core, active-high.
REQ-005 The block SHALL provide port color_en in 1: colour palette select (1=colour, 0=monochrome), from the OSD status bit.
REQ-006 The block SHALL provide ports r, g, b, each out 4: mixed pixel, unsigned.
REQ-007 The block SHALL provide ports hsync, vsync, hblank, vblank, each out 1: timing delayed to match r/g/b.

Function
REQ-008 The block SHALL be a 2-stage pipeline advancing only on ce_pix=1; r/g/b and timing outputs SHALL appear exactly 2 ce_pix cycles after the inputs are sampled, with timing and pixel data staying aligned.
REQ-009 Stage 1 SHALL register video, the four timing inputs, and the vsync rising-edge flag (vsync_in=1 while the previous sampled vsync_in=0).
REQ-010 Per-layer channel contributions SHALL be 0 when the layer bit is 0; otherwise the values in REQ-011..REQ-013 apply.
REQ-011 The star layer contribution SHALL be R=G=B=7 in both palettes.
REQ-012 The saucer layer contribution SHALL be R=0, G=15, B=15 in colour mode and R=G=B=7 in monochrome.
REQ-013 The rocket layer contribution SHALL be R=15, G=15, B=0 in colour mode and R=G=B=15 in monochrome.
REQ-014 Stage 2 SHALL sum each channel in 6 bits and saturate to 15 when the sum exceeds 15; there SHALL be no wrap-around.
REQ-015 Stage 2 SHALL XOR each saturated channel with {4{inv}}.
REQ-016 The stage-2 output SHALL be forced to 0 on all channels (no inversion applied) while the delayed hblank or vblank is 1.
REQ-017 The invert accumulator SHALL OR in video[3] on every ce_pix cycle.
REQ-018 On a sampled vsync rising edge, inv SHALL load the accumulator value and the accumulator SHALL reload with the current video[3] rather than 0, so a request on the edge cycle counts toward the new frame.
REQ-019 color_en SHALL be captured into an internal palette register only on a sampled vsync rising edge; a mid-frame change SHALL NOT alter the current frame.
REQ-020 With ce_pix=0, all registers and outputs SHALL hold their values.

Reset
REQ-021 While reset_n=0, all outputs SHALL be 0 and inv, the accumulator, and the previous-vsync register SHALL be 0.
REQ-022 While reset_n=0, the palette register SHALL be 0 (monochrome).
REQ-023 Assertion of reset_n mid-frame SHALL clear state immediately (asynchronous).
REQ-024 After release of reset_n, the first valid pixel SHALL emerge after 2 ce_pix cycles.
REQ-025 inv SHALL remain 0 until the first vsync rising edge after reset release.

Structure
REQ-026 Package comspc_video_pkg SHALL hold the layer bit indices, the per-layer colour and monochrome RGB constants, and the saturation limit (15).
REQ-027 A single sub-module, comspc_invert_latch, SHALL contain the accumulator, the vsync edge detect, inv, and the palette register; the mixer arithmetic SHALL remain in the top module.

Verification
REQ-028 The bench SHALL cover: color_en=1 latched, video=0001 -> r,g,b = 7,7,7 two ce_pix later; video=0110 -> 15,15,15 (saturated); video=0010 -> 0,15,15.
REQ-029 The bench SHALL cover: color_en=0 latched, video=0111 -> 15,15,15; video=0011 -> 14,14,14; video=0000 -> 0,0,0.
REQ-030 The bench SHALL cover: video[3] pulsed once mid-frame N -> inv=1 for all of frame N+1 (video=0000 gives 15,15,15); no pulse in N+1 -> inv=0 in N+2.
REQ-031 The bench SHALL cover: video[3]=1 only on the vsync rising-edge cycle -> inv unchanged for the next frame, inv=1 for the frame after.
REQ-032 The bench SHALL cover: hblank_in=1 with video=0100 and inv=1 -> r,g,b = 0 and hblank=1 together, 2 ce_pix later.
REQ-033 The bench SHALL cover: ce_pix held low for 10 clocks mid-line -> outputs frozen; reset_n pulsed low mid-frame -> outputs and inv=0 immediately.
